// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall/flush control for the five-stage core, plus divide sequencing.
// Forwarding/stall/flush are zero-latency combinational; a divide holds ID/EX for DIV_CYCLES+1 cycles.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       div_startE,
    input  logic       exceptM,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       div_busy,
    output logic       div_done
);

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       div_stall;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    logic wm_vld, ww_vld, we_vld;
    assign wm_vld = regwriteM && (writeregM != 5'd0);
    assign ww_vld = regwriteW && (writeregW != 5'd0);
    assign we_vld = regwriteE && (writeregE != 5'd0);

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (wm_vld && writeregM == rsE)      forwardAE = 2'b10;
        else if (ww_vld && writeregW == rsE) forwardAE = 2'b01;
        if (wm_vld && writeregM == rtE)      forwardBE = 2'b10;
        else if (ww_vld && writeregW == rtE) forwardBE = 2'b01;
    end

    assign forwardAD = wm_vld && (writeregM == rsD);
    assign forwardBD = wm_vld && (writeregM == rtD);

    logic e_hits_d, m_load_hits_d, lw_stall, br_stall;
    assign e_hits_d      = we_vld && (writeregE == rsD || writeregE == rtD);
    assign m_load_hits_d = memtoregM && (writeregM != 5'd0) &&
                           (writeregM == rsD || writeregM == rtD);
    assign lw_stall      = memtoregE && e_hits_d;
    assign br_stall      = branchD && (e_hits_d || m_load_hits_d);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_stall = 1'b0;
        case (state)
            S_IDLE: begin
                if (div_startE) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = CNT_LOAD;
                    div_stall = 1'b1;
                end
            end
            S_BUSY: begin
                div_stall = 1'b1;
                if (cnt == 6'd0) state_nxt = S_DONE;
                else             cnt_nxt   = cnt - 6'd1;
            end
            // The divide is still in EX here; ignoring div_startE stops it relaunching.
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (exceptM) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 6'd0;
        end
    end

    assign div_busy = (state == S_BUSY);
    assign div_done = (state == S_DONE);

    // While ID/EX is held by a divide, a bubble must not be injected into it.
    assign stallF = !exceptM && (lw_stall || br_stall || div_stall);
    assign stallD = stallF;
    assign stallE = !exceptM && div_stall;
    assign flushD = exceptM;
    assign flushE = exceptM || (!div_stall && (lw_stall || br_stall));
    assign flushM = exceptM || div_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed table, hand sequences for divide/exception/reset, random vs model.
module tb_hazard_ctrl;

    localparam int N4 = 4;
    localparam int N1 = 1;

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
        logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
        logic branchD, div_startE, exceptM;
    } in_t;

    typedef struct packed {
        logic [1:0] fae, fbe;
        logic fad, fbd, sf, sd, se, fld, fle, flm, busy, done;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    in_t  cur = '0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    logic [1:0] fae4, fbe4, fae1, fbe1;
    logic fad4, fbd4, sf4, sd4, se4, fld4, fle4, flm4, busy4, done4;
    logic fad1, fbd1, sf1, sd1, se1, fld1, fle1, flm1, busy1, done1;
    out_t act4, act1;
    assign act4 = {fae4, fbe4, fad4, fbd4, sf4, sd4, se4, fld4, fle4, flm4, busy4, done4};
    assign act1 = {fae1, fbe1, fad1, fbd1, sf1, sd1, se1, fld1, fle1, flm1, busy1, done1};

    hazard_ctrl #(.DIV_CYCLES(N4)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(cur.rsD), .rtD(cur.rtD), .rsE(cur.rsE), .rtE(cur.rtE),
        .writeregE(cur.writeregE), .writeregM(cur.writeregM), .writeregW(cur.writeregW),
        .regwriteE(cur.regwriteE), .regwriteM(cur.regwriteM), .regwriteW(cur.regwriteW),
        .memtoregE(cur.memtoregE), .memtoregM(cur.memtoregM), .branchD(cur.branchD),
        .div_startE(cur.div_startE), .exceptM(cur.exceptM),
        .forwardAE(fae4), .forwardBE(fbe4), .forwardAD(fad4), .forwardBD(fbd4),
        .stallF(sf4), .stallD(sd4), .stallE(se4),
        .flushD(fld4), .flushE(fle4), .flushM(flm4),
        .div_busy(busy4), .div_done(done4)
    );

    hazard_ctrl #(.DIV_CYCLES(N1)) dut1 (
        .clk(clk), .resetn(resetn),
        .rsD(cur.rsD), .rtD(cur.rtD), .rsE(cur.rsE), .rtE(cur.rtE),
        .writeregE(cur.writeregE), .writeregM(cur.writeregM), .writeregW(cur.writeregW),
        .regwriteE(cur.regwriteE), .regwriteM(cur.regwriteM), .regwriteW(cur.regwriteW),
        .memtoregE(cur.memtoregE), .memtoregM(cur.memtoregM), .branchD(cur.branchD),
        .div_startE(cur.div_startE), .exceptM(cur.exceptM),
        .forwardAE(fae1), .forwardBE(fbe1), .forwardAD(fad1), .forwardBD(fbd1),
        .stallF(sf1), .stallD(sd1), .stallE(se1),
        .flushD(fld1), .flushE(fle1), .flushM(flm1),
        .div_busy(busy1), .div_done(done1)
    );

    task automatic chk(string nm, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", nm, got, exp);
        end
    endtask

    // Drive point: 2 time units after the active edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic add(string nm, in_t i, out_t e);
        vec_t v;
        v.name = nm;
        v.in   = i;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    // Divider is described by "age": -1 when idle, else cycles since the start cycle.
    function automatic out_t model(in_t i, int age, int n);
        out_t o;
        logic hit_e, hit_m, lw, br, ds;
        o = '0;
        if (i.regwriteM && i.writeregM != 0 && i.writeregM == i.rsE)      o.fae = 2'b10;
        else if (i.regwriteW && i.writeregW != 0 && i.writeregW == i.rsE) o.fae = 2'b01;
        if (i.regwriteM && i.writeregM != 0 && i.writeregM == i.rtE)      o.fbe = 2'b10;
        else if (i.regwriteW && i.writeregW != 0 && i.writeregW == i.rtE) o.fbe = 2'b01;
        o.fad = i.regwriteM && i.writeregM != 0 && i.writeregM == i.rsD;
        o.fbd = i.regwriteM && i.writeregM != 0 && i.writeregM == i.rtD;
        hit_e = i.regwriteE && i.writeregE != 0 && (i.writeregE == i.rsD || i.writeregE == i.rtD);
        hit_m = i.memtoregM && i.writeregM != 0 && (i.writeregM == i.rsD || i.writeregM == i.rtD);
        lw = i.memtoregE && hit_e;
        br = i.branchD && (hit_e || hit_m);
        ds = (age < 0 && i.div_startE) || (age >= 1 && age <= n);
        o.sf   = !i.exceptM && (lw || br || ds);
        o.sd   = o.sf;
        o.se   = !i.exceptM && ds;
        o.fld  = i.exceptM;
        o.fle  = i.exceptM || (!ds && (lw || br));
        o.flm  = i.exceptM || ds;
        o.busy = age >= 1 && age <= n;
        o.done = age == n + 1;
        return o;
    endfunction

    function automatic int next_age(in_t i, int age, int n);
        if (i.exceptM)     return -1;
        if (age < 0)       return i.div_startE ? 1 : -1;
        if (age <= n)      return age + 1;
        return -1;
    endfunction

    initial begin
        in_t  t;
        out_t e;
        int   age4, age1;

        // Reset state
        #3;
        chk("reset_n4", act4, '0);
        chk("reset_n1", act1, '0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        #1;
        chk("idle_all_zero", act4, '0);

        // Directed combinational table (divider stays idle)
        t = '0; e = '0;
        add("all_zero", t, e);
        t = '0; t.rsE = 5; t.writeregM = 5; t.regwriteM = 1; t.writeregW = 5; t.regwriteW = 1;
        e = '0; e.fae = 2'b10;
        add("fwd_m_priority", t, e);
        t.regwriteM = 0; e.fae = 2'b01;
        add("fwd_w", t, e);
        t.writeregW = 0; e.fae = 2'b00;
        add("fwd_w_reg0", t, e);
        t = '0; t.rtE = 7; t.writeregW = 7; t.regwriteW = 1;
        e = '0; e.fbe = 2'b01;
        add("fwd_b_w", t, e);
        t = '0; t.regwriteM = 1; t.regwriteW = 1; t.regwriteE = 1; t.memtoregE = 1;
        e = '0;
        add("reg0_never_matches", t, e);
        t = '0; t.memtoregE = 1; t.regwriteE = 1; t.writeregE = 8; t.rtD = 8;
        e = '0; e.sf = 1; e.sd = 1; e.fle = 1;
        add("load_use", t, e);
        t.regwriteE = 0; e = '0;
        add("load_no_regwrite", t, e);
        t = '0; t.memtoregM = 1; t.regwriteM = 1; t.writeregM = 8; t.rtD = 8;
        e = '0; e.fbd = 1;
        add("load_in_m_no_branch", t, e);
        t = '0; t.branchD = 1; t.rsD = 3; t.regwriteE = 1; t.writeregE = 3;
        e = '0; e.sf = 1; e.sd = 1; e.fle = 1;
        add("branch_hazard_e", t, e);
        t = '0; t.branchD = 1; t.rsD = 3; t.writeregM = 3; t.regwriteM = 1;
        e = '0; e.fad = 1;
        add("branch_fwd_m", t, e);
        t = '0; t.branchD = 1; t.rtD = 9; t.writeregM = 9; t.memtoregM = 1; t.regwriteM = 1;
        e = '0; e.fbd = 1; e.sf = 1; e.sd = 1; e.fle = 1;
        add("branch_load_in_m", t, e);
        t = '0; t.memtoregE = 1; t.regwriteE = 1; t.writeregE = 8; t.rtD = 8; t.exceptM = 1;
        e = '0; e.fld = 1; e.fle = 1; e.flm = 1;
        add("except_over_load_use", t, e);

        foreach (tbl[k]) begin
            cur = tbl[k].in;
            #1;
            chk(tbl[k].name, act4, tbl[k].exp);
            next_cycle();
        end

        // Divide sequence, N=4, start held through cycle 5
        cur = '0;
        next_cycle();
        cur.div_startE = 1;
        for (int c = 0; c <= 5; c++) begin
            #1;
            e = '0;
            if (c <= 4) begin
                e.sf = 1; e.sd = 1; e.se = 1; e.flm = 1;
                e.busy = (c >= 1);
            end else begin
                e.done = 1;
            end
            chk($sformatf("div_cycle%0d", c), act4, e);
            next_cycle();
        end
        cur.div_startE = 0;
        #1;
        chk("div_cycle6_idle", act4, '0);

        // Exception abort in cycle 2 of a divide
        next_cycle();
        cur.div_startE = 1;
        next_cycle();
        next_cycle();
        cur.exceptM = 1;
        #1;
        e = '0; e.fld = 1; e.fle = 1; e.flm = 1; e.busy = 1;
        chk("except_abort_cycle2", act4, e);
        next_cycle();
        cur.exceptM = 0;
        #1;
        e = '0; e.sf = 1; e.sd = 1; e.se = 1; e.flm = 1;
        chk("except_cycle3_restart", act4, e);
        next_cycle();
        cur.div_startE = 0;
        for (int c = 0; c < 5; c++) next_cycle();
        #1;
        chk("except_restart_finishes", act4, '0);

        // Asynchronous reset in the middle of BUSY
        next_cycle();
        cur.div_startE = 1;
        next_cycle();
        #1;
        e = '0; e.sf = 1; e.sd = 1; e.se = 1; e.flm = 1; e.busy = 1;
        chk("async_pre_busy", act4, e);
        #1;
        resetn = 1'b0;
        cur.div_startE = 0;
        #1;
        chk("async_reset_immediate", act4, '0);
        #1;
        resetn = 1'b1;
        next_cycle();
        #1;
        chk("after_reset_release", act4, '0);

        // Random stimulus against the reference model, both divider lengths
        resetn = 1'b0;
        cur = '0;
        #3;
        resetn = 1'b1;
        next_cycle();
        age4 = -1;
        age1 = -1;
        for (int k = 0; k < 500; k++) begin
            cur.rsD        = 5'($urandom_range(0, 3));
            cur.rtD        = 5'($urandom_range(0, 3));
            cur.rsE        = 5'($urandom_range(0, 3));
            cur.rtE        = 5'($urandom_range(0, 3));
            cur.writeregE  = 5'($urandom_range(0, 3));
            cur.writeregM  = 5'($urandom_range(0, 3));
            cur.writeregW  = 5'($urandom_range(0, 3));
            cur.regwriteE  = 1'($urandom_range(0, 1));
            cur.regwriteM  = 1'($urandom_range(0, 1));
            cur.regwriteW  = 1'($urandom_range(0, 1));
            cur.memtoregE  = ($urandom_range(0, 9) < 3);
            cur.memtoregM  = ($urandom_range(0, 9) < 3);
            cur.branchD    = ($urandom_range(0, 9) < 3);
            cur.div_startE = ($urandom_range(0, 9) < 3);
            cur.exceptM    = ($urandom_range(0, 19) == 0);
            #1;
            chk($sformatf("rand_n4_%0d", k), act4, model(cur, age4, N4));
            chk($sformatf("rand_n1_%0d", k), act1, model(cur, age1, N1));
            age4 = next_age(cur, age4, N4);
            age1 = next_age(cur, age1, N1);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall/flush controller for the five-stage MIPS core. It drives the enable (stall) and clear (flush) controls of the IF/ID, ID/EX and EX/MEM pipeline registers and generates forwarding selects for the EX and ID stages. It also sequences multi-cycle divide instructions so that the divide holds the ID/EX register for a fixed number of cycles. It sits beside the datapath and observes only register numbers and control bits.

## Interface
- DIV_CYCLES, 32, number of cycles the divider needs; legal range 1–63.
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- rsD, rtD  in  5  source register numbers in ID
- rsE, rtE  in  5  source register numbers in EX
- writeregE, writeregM, writeregW  in  5  destination registers per stage
- regwriteE, regwriteM, regwriteW  in  1  register-write enables per stage
- memtoregE, memtoregM  in  1  load-in-stage flags
- branchD  in  1  branch/jr being resolved in ID (compare in ID)
- div_startE  in  1  divide instruction present in EX (level, held while in EX)
- exceptM  in  1  exception/eret taken in MEM
- forwardAE, forwardBE  out  2  EX operand select: 00 regfile, 01 W result, 10 M result
- forwardAD, forwardBD  out  1  ID compare operand select: 1 = M result
- stallF, stallD, stallE  out  1  hold PC, IF/ID, ID/EX
- flushD, flushE, flushM  out  1  clear IF/ID, ID/EX, EX/MEM
- div_busy  out  1  divide sequence in progress (registered state)
- div_done  out  1  one-cycle pulse, divide result valid in EX

## Operation
- Register 0 never matches; every match term requires the destination to be nonzero.
- forwardAE = 10 if regwriteM and writeregM==rsE; else 01 if regwriteW and writeregW==rsE; else 00. M has priority over W. The same rule applies to forwardBE with rtE.
- forwardAD = regwriteM and writeregM==rsD. The same rule applies to forwardBD with rtD.
- lw_stall = memtoregE and regwriteE and writeregE ∈ {rsD, rtD}.
- br_stall = branchD and ((regwriteE and writeregE ∈ {rsD, rtD}) or (memtoregM and writeregM ∈ {rsD, rtD})).
- Divide FSM states:
  - IDLE: if div_startE, go to BUSY and load the counter with DIV_CYCLES-1.
  - BUSY: decrement the counter; when counter==0, go to DONE.
  - DONE: go to IDLE unconditionally. div_startE is ignored in DONE, so the same divide does not restart.
- div_stall = (IDLE and div_startE) or BUSY.
- div_done = 1 in DONE.
- div_busy = 1 in BUSY.
- Output equations:
  - stallF = stallD = ~exceptM and (lw_stall or br_stall or div_stall).
  - stallE = ~exceptM and div_stall.
  - flushE = exceptM or (~div_stall and (lw_stall or br_stall)).
  - flushM = exceptM or div_stall.
  - flushD = exceptM.
- Priority: exceptM, then div_stall, then lw_stall/br_stall.
- exceptM in any state forces the next state to IDLE and clears the counter at the next edge. Stall outputs are 0 in that cycle.
- Counter width: 6 bits.

## Timing
- Reset (resetn low, asynchronous): state IDLE, counter 0, div_busy 0, div_done 0.
- All other outputs are combinational from inputs and state. With all inputs 0, every output is 0.
- Forwarding, stall and flush outputs: zero-latency combinational.
- Divide sequence for DIV_CYCLES=N, starting with div_startE first high in cycle t:
  - stallE and flushM high for cycles t … t+N.
  - div_busy high for cycles t+1 … t+N.
  - div_done high in cycle t+N+1 with stallE low; the ID/EX register advances at the end of t+N+1.
- N=1: one BUSY cycle, then DONE.
- Reset released mid-divide: the sequence is abandoned; the EX instruction is re-seen as a new start.
- lw_stall during a divide: flushE is suppressed because ID/EX is held; the stall persists until the divide ends.

## Test plan
- Forwarding priority: rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=10. Drop regwriteM -> 01. Set writeregW=0 -> 00.
- Load-use: memtoregE=1, regwriteE=1, writeregE=8, rtD=8 -> stallF=stallD=flushE=1, stallE=0 for one cycle. Then memtoregM path, branchD=0 -> no stall.
- Branch hazard: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stallF=stallD=flushE=1. Next cycle writeregM=3, regwriteM=1, memtoregM=0 -> stall 0, forwardAD=1.
- Divide, DIV_CYCLES=4: div_startE held high from cycle 0 -> stallE=1 for cycles 0–4, div_busy cycles 1–4, div_done=1 and stallE=0 at cycle 5, IDLE at cycle 6.
- Exception abort: div_startE high, exceptM pulsed at cycle 2 -> flushD=flushE=flushM=1 and stalls 0 in cycle 2; div_busy=0 from cycle 3.
- Async reset: pull resetn low mid-BUSY between edges -> div_busy=0 immediately; after release with div_startE=0, all outputs 0.
